// File: rtl/fifo_button_ctrl.sv
// fifo_button_ctrl: debounces two push-buttons and turns each press into a
// single FIFO write or read strobe, tracking occupancy and flagging dropped
// presses. Single clock domain (clkIn), synchronous active-high reset.
`timescale 1ns/1ps
module fifo_button_ctrl #(
  parameter int unsigned DATA_WIDTH      = 6,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned CNT_W           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clkIn,
  input  logic                  sysResetIn,
  input  logic                  writeBtnIn,
  input  logic                  readBtnIn,
  output logic                  fifoWriteEnableOut,
  output logic                  fifoReadEnableOut,
  output logic [DATA_WIDTH-1:0] fifoDataOut,
  output logic [CNT_W-1:0]      countOut,
  output logic                  fullOut,
  output logic                  emptyOut,
  output logic                  overflowOut,
  output logic                  underflowOut
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [DATA_WIDTH-1:0] altPattern();
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) p[i] = i[0];
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] DATA_INIT = altPattern();

  typedef enum logic [1:0] {IDLE, WRITE, READ} stateType;

  // Index 0 = write button, index 1 = read button.
  logic [1:0]      btnRaw;
  logic [1:0]      meta;
  logic [1:0]      synced;
  logic [1:0]      debounced;
  logic [DB_W-1:0] dbCnt [2];
  logic [1:0]      rise;
  logic [1:0]      pending;
  logic [1:0]      clrPend;

  stateType state;
  stateType nextState;
  logic     setOver;
  logic     setUnder;

  assign btnRaw = {readBtnIn, writeBtnIn};

  // Synchronize each raw button and accept a new level after DEBOUNCE_CYCLES stable cycles.
  always_ff @(posedge clkIn) begin
    if (sysResetIn) begin
      meta      <= '0;
      synced    <= '0;
      debounced <= '0;
      for (int unsigned i = 0; i < 2; i++) dbCnt[i] <= '0;
    end else begin
      meta   <= btnRaw;
      synced <= meta;
      for (int unsigned i = 0; i < 2; i++) begin
        if (synced[i] != debounced[i]) begin
          if (dbCnt[i] == DB_MAX) begin
            debounced[i] <= synced[i];
            dbCnt[i]     <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + 1'b1;
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end

  // Detect the cycle on which a debounced level is about to rise.
  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < 2; i++)
      rise[i] = !debounced[i] && synced[i] && (dbCnt[i] == DB_MAX);
  end

  // Latch accepted presses until the FSM serves or drops them.
  always_ff @(posedge clkIn) begin
    if (sysResetIn) begin
      pending <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (rise[i])         pending[i] <= 1'b1;
        else if (clrPend[i]) pending[i] <= 1'b0;
      end
    end
  end

  assign fullOut  = (countOut == CNT_W'(FIFO_DEPTH));
  assign emptyOut = (countOut == '0);

  // Next-state decode: legal read wins; an illegal read is dropped without blocking a legal write.
  always_comb begin
    nextState = state;
    clrPend   = '0;
    setOver   = 1'b0;
    setUnder  = 1'b0;
    case (state)
      IDLE: begin
        if (pending[1] && !emptyOut) begin
          nextState  = READ;
          clrPend[1] = 1'b1;
        end else begin
          if (pending[1]) begin
            clrPend[1] = 1'b1;
            setUnder   = 1'b1;
          end
          if (pending[0] && !fullOut) begin
            nextState  = WRITE;
            clrPend[0] = 1'b1;
          end else if (pending[0]) begin
            clrPend[0] = 1'b1;
            setOver    = 1'b1;
          end
        end
      end
      WRITE:   nextState = IDLE;
      READ:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register plus occupancy, data pattern and sticky flags updated on strobe exit.
  always_ff @(posedge clkIn) begin
    if (sysResetIn) begin
      state        <= IDLE;
      countOut     <= '0;
      fifoDataOut  <= DATA_INIT;
      overflowOut  <= 1'b0;
      underflowOut <= 1'b0;
    end else begin
      state <= nextState;
      if (state == WRITE) begin
        countOut    <= countOut + 1'b1;
        fifoDataOut <= ~fifoDataOut;
      end else if (state == READ) begin
        countOut <= countOut - 1'b1;
      end
      if (setOver)  overflowOut  <= 1'b1;
      if (setUnder) underflowOut <= 1'b1;
    end
  end

  // Strobes decode straight from the registered state.
  always_comb begin
    fifoWriteEnableOut = (state == WRITE);
    fifoReadEnableOut  = (state == READ);
  end

endmodule

// File: tb/tb_fifo_button_ctrl.sv
// Directed bench for fifo_button_ctrl with short debounce and a 2-deep FIFO.
`timescale 1ns/1ps
module tb_fifo_button_ctrl;

  logic       clkIn = 1'b0;
  logic       sysResetIn = 1'b1;
  logic       writeBtnIn = 1'b0;
  logic       readBtnIn = 1'b0;
  logic       fifoWriteEnableOut;
  logic       fifoReadEnableOut;
  logic [5:0] fifoDataOut;
  logic [1:0] countOut;
  logic       fullOut;
  logic       emptyOut;
  logic       overflowOut;
  logic       underflowOut;

  int total = 0;
  int bad = 0;

  int cycle = 0;
  int wrStrobes = 0;
  int rdStrobes = 0;
  int bothHigh = 0;
  int wrCycle = 0;
  int rdCycle = 0;
  logic [5:0] lastWrData = '0;

  int wrBefore;
  int rdBefore;
  bit seen;

  fifo_button_ctrl #(
    .DATA_WIDTH(6),
    .FIFO_DEPTH(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clkIn(clkIn),
    .sysResetIn(sysResetIn),
    .writeBtnIn(writeBtnIn),
    .readBtnIn(readBtnIn),
    .fifoWriteEnableOut(fifoWriteEnableOut),
    .fifoReadEnableOut(fifoReadEnableOut),
    .fifoDataOut(fifoDataOut),
    .countOut(countOut),
    .fullOut(fullOut),
    .emptyOut(emptyOut),
    .overflowOut(overflowOut),
    .underflowOut(underflowOut)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) begin
    cycle = cycle + 1;
    if (fifoWriteEnableOut) begin
      wrStrobes = wrStrobes + 1;
      wrCycle = cycle;
      lastWrData = fifoDataOut;
    end
    if (fifoReadEnableOut) begin
      rdStrobes = rdStrobes + 1;
      rdCycle = cycle;
    end
    if (fifoWriteEnableOut && fifoReadEnableOut) bothHigh = bothHigh + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clkIn);
    sysResetIn = 1'b1;
    writeBtnIn = 1'b0;
    readBtnIn = 1'b0;
    repeat (3) @(negedge clkIn);
    sysResetIn = 1'b0;
    @(negedge clkIn);
  endtask

  task automatic press(input logic doWrite, input logic doRead, input int holdCycles);
    @(negedge clkIn);
    writeBtnIn = doWrite;
    readBtnIn = doRead;
    repeat (holdCycles) @(negedge clkIn);
    writeBtnIn = 1'b0;
    readBtnIn = 1'b0;
    repeat (12) @(negedge clkIn);
  endtask

  initial begin
    // Reset state
    doReset();
    check("rst_wr_strobe", 32'(fifoWriteEnableOut), 32'd0);
    check("rst_rd_strobe", 32'(fifoReadEnableOut), 32'd0);
    check("rst_count", 32'(countOut), 32'd0);
    check("rst_empty", 32'(emptyOut), 32'd1);
    check("rst_full", 32'(fullOut), 32'd0);
    check("rst_data", 32'(fifoDataOut), 32'h2A);
    check("rst_over", 32'(overflowOut), 32'd0);
    check("rst_under", 32'(underflowOut), 32'd0);

    // Read while empty is dropped
    press(1'b0, 1'b1, 10);
    check("underflow_no_strobe", 32'(rdStrobes), 32'd0);
    check("underflow_flag", 32'(underflowOut), 32'd1);
    check("underflow_count", 32'(countOut), 32'd0);

    // Sticky flag clears on reset; clean write press
    doReset();
    check("under_cleared", 32'(underflowOut), 32'd0);
    press(1'b1, 1'b0, 10);
    check("wr1_strobes", 32'(wrStrobes), 32'd1);
    check("wr1_data", 32'(lastWrData), 32'h2A);
    check("wr1_count", 32'(countOut), 32'd1);
    check("wr1_next_data", 32'(fifoDataOut), 32'h15);
    check("wr1_empty", 32'(emptyOut), 32'd0);

    // 3-cycle glitch is rejected
    press(1'b1, 1'b0, 3);
    check("glitch_strobes", 32'(wrStrobes), 32'd1);
    check("glitch_count", 32'(countOut), 32'd1);

    // Second write fills, third overflows
    press(1'b1, 1'b0, 10);
    check("wr2_strobes", 32'(wrStrobes), 32'd2);
    check("wr2_data", 32'(lastWrData), 32'h15);
    check("wr2_full", 32'(fullOut), 32'd1);
    check("wr2_count", 32'(countOut), 32'd2);
    check("wr2_over_clear", 32'(overflowOut), 32'd0);
    press(1'b1, 1'b0, 10);
    check("wr3_strobes", 32'(wrStrobes), 32'd2);
    check("wr3_over", 32'(overflowOut), 32'd1);
    check("wr3_count", 32'(countOut), 32'd2);
    check("wr3_full", 32'(fullOut), 32'd1);

    // Simultaneous read and write with one word held
    doReset();
    press(1'b1, 1'b0, 10);
    check("sim_pre_count", 32'(countOut), 32'd1);
    wrBefore = wrStrobes;
    rdBefore = rdStrobes;
    press(1'b1, 1'b1, 10);
    check("sim_rd_strobes", 32'(rdStrobes - rdBefore), 32'd1);
    check("sim_wr_strobes", 32'(wrStrobes - wrBefore), 32'd1);
    check("sim_spacing", 32'(wrCycle - rdCycle), 32'd2);
    check("sim_count", 32'(countOut), 32'd1);
    check("sim_under", 32'(underflowOut), 32'd0);

    // Reset asserted in the WRITE cycle
    doReset();
    wrBefore = wrStrobes;
    @(negedge clkIn);
    writeBtnIn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkIn);
      if (fifoWriteEnableOut) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstw_strobe_seen", 32'(seen), 32'd1);
    sysResetIn = 1'b1;
    writeBtnIn = 1'b0;
    @(negedge clkIn);
    check("rstw_strobe_low", 32'(fifoWriteEnableOut), 32'd0);
    check("rstw_count", 32'(countOut), 32'd0);
    sysResetIn = 1'b0;
    repeat (15) @(negedge clkIn);
    check("rstw_no_pending", 32'(wrStrobes - wrBefore), 32'd1);
    check("rstw_count_after", 32'(countOut), 32'd0);
    check("rstw_data", 32'(fifoDataOut), 32'h2A);

    check("never_both_strobes", 32'(bothHigh), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
